// File: rtl/speedy_pkg.sv
// speedy_pkg: constants shared by the Speedy-6-192 decryption core.
//   L, W        : row count and block width (rows are 6 bits wide)
//   ST_*        : FSM state encodings
//   SBOX        : forward 6-bit S-box, kept so the inverse table can be derived from it
//   INV_SBOX    : 64-entry inverse S-box table
//   SC_STEP     : column j of the shift-columns layer rotates by j*SC_STEP rows
//   MC_MASK     : row offsets XORed together by the mixing layer (bit k = offset k)
//   INV_MC_MASK : row offsets of the inverse mixing layer
// Bit layout of a block: row i occupies bits [6*i+5 : 6*i]; bit j of a row is column j.
package speedy_pkg;

   localparam int L = 32;
   localparam int W = 6 * L;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_FIN  = 3'd1;
   localparam logic [2:0] ST_RND  = 3'd2;
   localparam logic [2:0] ST_WHT  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef logic [0:63][5:0] sbox_t;

   localparam sbox_t SBOX = {
      6'h08, 6'h00, 6'h09, 6'h03, 6'h38, 6'h10, 6'h29, 6'h13,
      6'h0c, 6'h0d, 6'h04, 6'h07, 6'h30, 6'h01, 6'h20, 6'h23,
      6'h1a, 6'h12, 6'h18, 6'h32, 6'h3e, 6'h16, 6'h2c, 6'h36,
      6'h1c, 6'h1d, 6'h14, 6'h37, 6'h34, 6'h05, 6'h24, 6'h27,
      6'h02, 6'h06, 6'h0b, 6'h0f, 6'h33, 6'h17, 6'h21, 6'h15,
      6'h0a, 6'h1b, 6'h0e, 6'h1f, 6'h31, 6'h11, 6'h25, 6'h35,
      6'h22, 6'h26, 6'h2a, 6'h2e, 6'h3a, 6'h1e, 6'h28, 6'h3c,
      6'h2b, 6'h3b, 6'h2f, 6'h3f, 6'h39, 6'h19, 6'h2d, 6'h3d
   };

   localparam int SC_STEP = 1;

   // Offsets {0,1,5,9,15,21,26}
   localparam logic [L-1:0] MC_MASK = 32'h0420_8223;

   function automatic sbox_t invert_sbox(input sbox_t s);
      sbox_t r;
      r = '0;
      for (int i = 0; i < 64; i++) r[s[i]] = 6'(i);
      return r;
   endfunction

   // Product of two circulant masks (cyclic convolution over GF(2)).
   function automatic logic [L-1:0] cyc_mul(input logic [L-1:0] a, input logic [L-1:0] b);
      logic [L-1:0] r;
      r = '0;
      for (int i = 0; i < L; i++)
         for (int k = 0; k < L; k++)
            if (a[i] && b[k]) r[(i + k) % L] = ~r[(i + k) % L];
      return r;
   endfunction

   // x^32+1 = (x+1)^32, so every odd-weight circulant u satisfies u^32 = 1
   // and its inverse is u^31, built here as u^3, u^7, u^15, u^31.
   function automatic logic [L-1:0] cyc_inv(input logic [L-1:0] a);
      logic [L-1:0] r;
      r = a;
      for (int n = 0; n < 4; n++) r = cyc_mul(cyc_mul(r, r), a);
      return r;
   endfunction

   localparam sbox_t          INV_SBOX    = invert_sbox(SBOX);
   localparam logic [L-1:0]   INV_MC_MASK = cyc_inv(MC_MASK);

endpackage

// File: rtl/speedy_dec_core_if.sv
// speedy_dec_core_if: ciphertext input, round-key lookup and plaintext output
// of the decryption core.
//   in_valid/in_ready/in_data    : ciphertext handshake
//   rk_idx/rk_in                 : round-key request, answered combinationally
//   out_valid/out_ready/out_data : plaintext handshake
// master = environment side, slave = core side.
interface speedy_dec_core_if #(
   parameter int W = speedy_pkg::W
);
   import speedy_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [3:0]   rk_idx;
   logic [W-1:0] rk_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;

   modport master (
      output in_valid, in_data, rk_in, out_ready,
      input  in_ready, rk_idx, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, rk_in, out_ready,
      output in_ready, rk_idx, out_valid, out_data
   );
endinterface

// File: rtl/speedy_inv_round.sv
// speedy_inv_round: combinational inverse round of Speedy-6-192.
//   state_i : current state
//   rk_i    : round key (used only for the full round)
//   fin_i   : 1 -> invS(invSC(invS(state)))                       (final-round inverse)
//             0 -> invS(invSC(invS(invSC(invMC(state ^ rk)))))     (full-round inverse)
//   next_o  : next state
module speedy_inv_round
   import speedy_pkg::*;
(
   input  logic [W-1:0] state_i,
   input  logic [W-1:0] rk_i,
   input  logic         fin_i,
   output logic [W-1:0] next_o
);

   // Forward shift moves row i+j of column j to row i; undo that here.
   function automatic logic [W-1:0] inv_sc(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < L; i++)
         for (int j = 0; j < 6; j++)
            r[6*i + j] = v[6*((i - SC_STEP*j + L) % L) + j];
      return r;
   endfunction

   // Each column is multiplied by the inverse circulant: row i collects
   // rows i+k for every offset k set in INV_MC_MASK.
   function automatic logic [W-1:0] inv_mc(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < 6; j++)
         for (int i = 0; i < L; i++)
            for (int k = 0; k < L; k++)
               if (INV_MC_MASK[k]) r[6*i + j] = r[6*i + j] ^ v[6*((i + k) % L) + j];
      return r;
   endfunction

   logic [W-1:0] pre_mix;
   logic [W-1:0] sub1;
   logic [W-1:0] shf2;

   assign pre_mix = fin_i ? state_i : inv_sc(inv_mc(state_i ^ rk_i));

   for (genvar gi = 0; gi < L; gi++) begin : g_sub1
      assign sub1[6*gi +: 6] = INV_SBOX[pre_mix[6*gi +: 6]];
   end

   assign shf2 = inv_sc(sub1);

   for (genvar gi = 0; gi < L; gi++) begin : g_sub2
      assign next_o[6*gi +: 6] = INV_SBOX[shf2[6*gi +: 6]];
   end

endmodule

// File: rtl/speedy_dec_core.sv
// speedy_dec_core: iterative Speedy-6-192 decryption, one inverse round per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : speedy_dec_core_if.slave (ciphertext in, round-key lookup, plaintext out)
// Flow: IDLE (whiten with K_R) -> FIN (final-round inverse) -> RND x (ROUNDS-1)
// -> WHT (xor K0) -> DONE (hold plaintext until accepted) -> IDLE.
// L must match speedy_pkg::L; the layer constants assume 32 rows.
module speedy_dec_core
   import speedy_pkg::*;
#(
   parameter int ROUNDS = 6,
   parameter int L      = speedy_pkg::L
)
(
   input  logic             clk,
   input  logic             rst,
   speedy_dec_core_if.slave bus
);

   localparam int         BW = 6 * L;
   localparam logic [3:0] R  = 4'(ROUNDS);

   logic [2:0]    fsm_q, fsm_d;
   logic [BW-1:0] state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [BW-1:0] round_out;
   logic          fin_sel;
   logic          in_ready;
   logic          out_valid;
   logic [3:0]    rk_idx;

   assign fin_sel = (fsm_q == ST_FIN);

   speedy_inv_round u_inv_round (
      .state_i (state_q),
      .rk_i    (bus.rk_in),
      .fin_i   (fin_sel),
      .next_o  (round_out)
   );

   always_comb begin
      fsm_d     = fsm_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      rk_idx    = 4'd0;
      case (fsm_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            rk_idx   = R;
            if (bus.in_valid) begin
               state_d = bus.in_data ^ bus.rk_in;
               fsm_d   = ST_FIN;
            end
         end
         ST_FIN: begin
            // K_R stays requested here so the key index sequence is R,R,R-1..1,0
            rk_idx  = R;
            state_d = round_out;
            cnt_d   = R - 4'd1;
            fsm_d   = ST_RND;
         end
         ST_RND: begin
            rk_idx  = cnt_q;
            state_d = round_out;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd1) fsm_d = ST_WHT;
         end
         ST_WHT: begin
            rk_idx  = 4'd0;
            state_d = state_q ^ bus.rk_in;
            fsm_d   = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) fsm_d = ST_IDLE;
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         cnt_q   <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = state_q;
   assign bus.rk_idx    = rk_idx;

endmodule

// File: doc/speedy_dec_core.md
SPEEDY_DEC_CORE -- requirements
Module: speedy_dec_core

Interface
REQ-001 Parameter: ROUNDS, default 6, number of Speedy-6-192 rounds R; legal range 2..15.
REQ-002 Parameter: L, default 32, number of 6-bit rows; block width W = 6*L = 192.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: in_valid  input  1  ciphertext offered.
REQ-006 Port: in_ready  output  1  core idle and able to accept a ciphertext.
REQ-007 Port: in_data  input  W  ciphertext.
REQ-008 Port: rk_idx  output  4  index of the round key requested this cycle.
REQ-009 Port: rk_in  input  W  round key for rk_idx, returned combinationally in the same cycle.
REQ-010 Port: out_valid  output  1  plaintext available.
REQ-011 Port: out_ready  input  1  consumer accepts the plaintext.
REQ-012 Port: out_data  output  W  plaintext.

Function
REQ-013 Encryption being inverted: x0 = P ^ K0; x_i = MC(SC(S(SC(S(x_{i-1}))))) ^ AC_AK_i for i = 1..R-1; C = S(SC(S(x_{R-1}))) ^ K_R.
REQ-014 Key indexing: rk_in holds K_R at idx R, pre-combined AC_AK_i at idx i (1..R-1), and K0 at idx 0.
REQ-015 FSM states: IDLE, FIN, RND, WHT, DONE.
REQ-016 IDLE: in_ready=1, rk_idx=R; a transfer occurs when in_valid&in_ready; the state register loads in_data ^ rk_in; next state FIN.
REQ-017 FIN: state <= invS(invSC(invS(state))); round counter loads R-1; next state RND.
REQ-018 RND: rk_idx = counter; state <= invS(invSC(invS(invSC(invMC(state ^ rk_in))))); counter decrements; at counter=1 the next state is WHT.
REQ-019 WHT: rk_idx=0; state <= state ^ rk_in; next state DONE.
REQ-020 DONE: out_valid=1 and out_data=state, both held stable until out_ready=1; on out_valid&out_ready the next state is IDLE.
REQ-021 Latency: out_valid rises exactly R+1 cycles after the accepting edge (R=6 gives 7).
REQ-022 in_ready=0 in every state except IDLE; in_valid in those states is ignored and the data is not captured.
REQ-023 Back-to-back operation: a new ciphertext is accepted at the earliest one cycle after the output handshake, since DONE returns to IDLE.
REQ-024 out_ready asserted outside DONE has no effect.
REQ-025 rk_idx carries the value defined for the current state in every cycle; in DONE it is 0.
REQ-026 invS is the inverse of the Speedy 6-bit S-box, applied to each row.
REQ-027 invSC is the inverse column shift.
REQ-028 invMC is the inverse of the Speedy mixing layer.
REQ-029 All datapath operations are purely bitwise, with no width change.

Reset
REQ-030 Asserting rst forces, without waiting for a clock edge: state IDLE, state register 0, counter 0, in_ready=1, out_valid=0, out_data=0, rk_idx=R.
REQ-031 Reset asserted during FIN, RND, WHT or DONE aborts the operation; no out_valid is produced for the aborted block.
REQ-032 Reset deassertion takes effect on the next rising edge of clk.

Structure
REQ-033 The shared package speedy_pkg holds:
- L, W;
- the 64-entry inverse S-box table;
- the rotation offsets used by invSC and invMC;
- the FSM state enumeration.
REQ-034 One combinational sub-module, speedy_inv_round, implements invS/invSC/invMC with selects for the FIN and RND variants; the FSM, counter and registers reside in speedy_dec_core.

Verification
REQ-035 in_data = 0, all rk_in = 0 -> the bench reference model (an encryption model, run in inverse) gives the expected out_data; rk_idx must follow R,R,R-1..1,0 on consecutive cycles.
REQ-036 Random P and keys: C from the encryption model is fed in -> out_data == P, out_valid exactly 7 cycles after the accept edge for R=6.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and out_data is unchanged; release -> in_ready=1 on the next cycle.
REQ-038 Hold in_valid=1 with different data throughout an operation -> only the first ciphertext is decrypted, and the second is accepted only after returning to IDLE.
REQ-039 Assert rst during RND (counter=3) -> out_valid=0 and in_ready=1 immediately; a following fresh block decrypts correctly.
REQ-040 Run with ROUNDS=2 -> latency 3 cycles, and the round trip with the encryption model passes.
